// File: rtl/mux_4_1_pkg.sv
// Shared definitions for the 4:1 multiplexer: select type and encodings.
package mux_4_1_pkg;

   // Two-bit select index formed as {s1, s0}
   typedef logic [1:0] sel_t;

   // Select encodings, one per data input
   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux_4_1_core.sv
// Purely combinational 4:1 selection core, applied identically to every bit.
module mux_4_1_core
   import mux_4_1_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  sel_t             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] y
);

   // Flat decode with no priority; an unknown select yields an unknown result
   always_comb begin
      y = {WIDTH{1'bx}};
      case (sel)
         SEL_A:   y = a;
         SEL_B:   y = b;
         SEL_C:   y = c;
         SEL_D:   y = d;
         default: y = {WIDTH{1'bx}};
      endcase
   end

endmodule

// File: rtl/mux_4_1.sv
// 4:1 multiplexer with an optional output register (REG_OUT=1) or a
// direct combinational output (REG_OUT=0).
module mux_4_1
   import mux_4_1_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             s0,
   input  logic             s1,
   output logic [WIDTH-1:0] out
);

   sel_t             sel;
   logic [WIDTH-1:0] selected;

   assign sel = {s1, s0};

   mux_4_1_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .sel (sel),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .y   (selected)
   );

   generate
      if (REG_OUT) begin : g_reg
         logic [WIDTH-1:0] out_q;

         // Capture the selected input each rising edge; reset clears it at once
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_q <= '0;
            end else begin
               out_q <= selected;
            end
         end

         assign out = out_q;
      end else begin : g_comb
         // Clock and reset play no part in the combinational mode
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;
         assign out = selected;
      end
   endgenerate

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1: registered and combinational variants at
// widths 1 and 8, directed scenarios followed by randomized vectors.
module tb_mux_4_1;

   logic       clk;
   logic       rst_n;
   logic [7:0] a, b, c, d;
   logic       s0, s1;
   logic [0:0] out_r1, out_c1;
   logic [7:0] out_r8, out_c8;

   int vectors;
   int misses;

   // Expected registered output, maintained by the reference model
   logic [7:0] exp_r;

   mux_4_1 #(.WIDTH(1), .REG_OUT(1)) u_r1 (
      .clk(clk), .rst_n(rst_n), .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
      .s0(s0), .s1(s1), .out(out_r1));

   mux_4_1 #(.WIDTH(1), .REG_OUT(0)) u_c1 (
      .clk(clk), .rst_n(rst_n), .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
      .s0(s0), .s1(s1), .out(out_c1));

   mux_4_1 #(.WIDTH(8), .REG_OUT(1)) u_r8 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
      .s0(s0), .s1(s1), .out(out_r8));

   mux_4_1 #(.WIDTH(8), .REG_OUT(0)) u_c8 (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
      .s0(s0), .s1(s1), .out(out_c8));

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference selection: index a table of the four inputs by {s1,s0}
   function automatic logic [7:0] model_pick();
      logic [7:0] tbl [4];
      tbl[0] = a;
      tbl[1] = b;
      tbl[2] = c;
      tbl[3] = d;
      return tbl[2 * int'(s1) + int'(s0)];
   endfunction

   task automatic check(input string tag, input logic [7:0] observed,
                        input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         misses++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic check_comb(input string tag);
      logic [7:0] p;
      p = model_pick();
      check({tag, "_comb8"}, out_c8, p);
      check({tag, "_comb1"}, {7'd0, out_c1}, {7'd0, p[0]});
   endtask

   task automatic check_reg(input string tag);
      check({tag, "_reg8"}, out_r8, exp_r);
      check({tag, "_reg1"}, {7'd0, out_r1}, {7'd0, exp_r[0]});
   endtask

   // Drive all inputs between edges, then confirm the combinational outputs
   // follow and the registered outputs hold (or clear if reset asserts)
   task automatic apply_stimulus(input string tag, input logic [7:0] na,
                                 input logic [7:0] nb, input logic [7:0] nc,
                                 input logic [7:0] nd, input logic [1:0] sel,
                                 input logic rst);
      a     = na;
      b     = nb;
      c     = nc;
      d     = nd;
      s1    = sel[1];
      s0    = sel[0];
      rst_n = rst;
      if (!rst) exp_r = 8'h00;
      #1;
      check_comb(tag);
      check_reg({tag, "_hold"});
   endtask

   // Advance one rising edge, update the model, check, return to the falling edge
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst_n) exp_r = model_pick();
      else       exp_r = 8'h00;
      #1;
      check_reg({tag, "_edge"});
      @(negedge clk);
   endtask

   initial begin
      vectors = 0;
      misses  = 0;
      exp_r   = 8'h00;
      rst_n   = 1'b0;
      a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
      s0 = 1'b0; s1 = 1'b0;

      // Reset held: registered outputs zero, combinational outputs live
      @(negedge clk);
      apply_stimulus("rst_hold", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b0);
      tick("rst_hold");
      apply_stimulus("rst_hold2", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b11, 1'b0);
      tick("rst_hold2");

      // Release reset, then sweep all four selects (width-1 sees 1,0,1,0)
      apply_stimulus("sweep_a", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b1);
      tick("sweep_a");
      apply_stimulus("sweep_b", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b01, 1'b1);
      tick("sweep_b");
      apply_stimulus("sweep_c", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b10, 1'b1);
      tick("sweep_c");
      apply_stimulus("sweep_d", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b11, 1'b1);
      tick("sweep_d");

      // Hold select on c and toggle c between edges without a clock edge
      apply_stimulus("ctog0", 8'hA5, 8'h3C, 8'h12, 8'h00, 2'b10, 1'b1);
      tick("ctog0");
      apply_stimulus("ctog1", 8'hA5, 8'h3C, 8'hED, 8'h00, 2'b10, 1'b1);
      apply_stimulus("ctog2", 8'hA5, 8'h3C, 8'h12, 8'h00, 2'b10, 1'b1);
      apply_stimulus("ctog3", 8'hA5, 8'h3C, 8'h6B, 8'h00, 2'b10, 1'b1);
      tick("ctog3");

      // Select 00 -> 11 together with a new d in the same cycle
      apply_stimulus("seld0", 8'h5A, 8'h3C, 8'h6B, 8'h11, 2'b00, 1'b1);
      tick("seld0");
      apply_stimulus("seld1", 8'h5A, 8'h3C, 8'h6B, 8'hC7, 2'b11, 1'b1);
      tick("seld1");

      // Registered 1, then reset between edges clears immediately
      apply_stimulus("rmid0", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b1);
      tick("rmid0");
      #2;
      apply_stimulus("rmid_assert", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b0);
      tick("rmid_assert");
      apply_stimulus("rmid_busy", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b10, 1'b0);
      tick("rmid_busy");
      apply_stimulus("rmid_release", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b01, 1'b1);
      tick("rmid_release");
      apply_stimulus("rmid_after", 8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b1);
      tick("rmid_after");

      // Randomized vectors with occasional reset pulses
      for (int i = 0; i < 200; i++) begin
         apply_stimulus("rand", 8'($urandom), 8'($urandom), 8'($urandom),
                        8'($urandom), 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 15) != 0));
         if ($urandom_range(0, 3) == 0) begin
            apply_stimulus("rand_mid", 8'($urandom), 8'($urandom),
                           8'($urandom), 8'($urandom),
                           2'($urandom_range(0, 3)), rst_n);
         end
         tick("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule

// File: doc/mux_4_1.md
MUX_4_1 -- requirements
Module: mux_4_1

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the data width of a, b, c, d and out.
REQ-002 Parameter REG_OUT, default 1, SHALL select the output mode: 1 = registered output, 0 = purely combinational output.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port a, input, WIDTH bits, SHALL be data input 0.
REQ-006 Port b, input, WIDTH bits, SHALL be data input 1.
REQ-007 Port c, input, WIDTH bits, SHALL be data input 2.
REQ-008 Port d, input, WIDTH bits, SHALL be data input 3.
REQ-009 Port s0, input, 1 bit, SHALL be the select LSB.
REQ-010 Port s1, input, 1 bit, SHALL be the select MSB.
REQ-011 Port out, output, WIDTH bits, SHALL carry the selected data.

Function
REQ-012 The select index SHALL be {s1,s0}, decoded as 00 -> a, 01 -> b, 10 -> c, 11 -> d.
REQ-013 The selection SHALL be bitwise and identical for every bit of WIDTH.
REQ-014 With REG_OUT=1, out SHALL take the selected value at each rising clk edge, giving 1-cycle latency from input or select change.
REQ-015 With REG_OUT=1, out SHALL hold its value between clock edges, regardless of input activity.
REQ-016 With REG_OUT=0, out SHALL follow the selected input combinationally, with zero latency.
REQ-017 With REG_OUT=0, clk and rst_n SHALL have no effect on out.
REQ-018 A simultaneous change of select and data before a clk edge SHALL register the new data of the newly selected input.
REQ-019 Any select bit at X/Z SHALL drive out to X in simulation; no X-suppression logic is permitted.
REQ-020 The select decode SHALL have no priority and no default hold; all four encodings are fully specified.

Reset
REQ-021 With REG_OUT=1, assertion of rst_n=0 SHALL clear out to all zeros immediately, without waiting for clk.
REQ-022 While rst_n=0, out SHALL remain zero regardless of clk, data or select activity.
REQ-023 After deassertion of rst_n, the first rising clk edge SHALL load the selected input.
REQ-024 Reset asserted mid-operation SHALL override any pending update on the same edge.

Structure
REQ-025 A shared package mux_4_1_pkg SHALL hold the 2-bit select encoding constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10 and SEL_D=2'b11.
REQ-026 One combinational sub-module, mux_4_1_core, SHALL perform the selection, wrapped by the optional output register in mux_4_1.
REQ-027 The design SHALL contain no latches.
REQ-028 The design SHALL use a single clock domain.

Verification
REQ-029 Scenario 1: with a=1, b=0, c=1, d=0, REG_OUT=1, apply {s1,s0}=00, 01, 10, 11, one per clock -> out reads 1, 0, 1, 0, each one cycle after its select.
REQ-030 Scenario 2: same stimulus with REG_OUT=0 -> out reads 1, 0, 1, 0 with no clock dependence.
REQ-031 Scenario 3: with out=1 registered, assert rst_n=0 between clock edges -> out=0 at once; it stays 0 until the first edge after release, then shows the selected value.
REQ-032 Scenario 4: with WIDTH=8, a=8'hA5, b=8'h3C, c=8'hFF, d=8'h00, sweep all selects -> out reads A5, 3C, FF, 00.
REQ-033 Scenario 5: hold select 10, toggle c between clock edges without an edge -> registered out stays unchanged; at the next edge out equals the current c.
REQ-034 Scenario 6: change select 00 -> 11 and d in the same cycle -> the next edge registers the new d.
